// File: rtl/wb_cdb_arbiter_pkg.sv
// Shared types and helpers for the writeback / CDB arbitration slice.
package wb_cdb_arbiter_pkg;

  localparam int N_SRC   = 3;
  localparam int XLEN    = 32;
  localparam int PREG_W  = 7;
  localparam int TAG_W   = 4;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_BRU = 2'd1;
  localparam logic [1:0] SRC_LSU = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] prd;
    logic              rd_used;
    logic [TAG_W-1:0]  rob_tag;
    logic [XLEN-1:0]   data;
  } cdb_pkt_t;

  // Age is distance from the ROB head, so the compare is correct across tag wrap.
  function automatic logic is_younger(input logic [TAG_W-1:0] tag,
                                      input logic [TAG_W-1:0] ref_tag,
                                      input logic [TAG_W-1:0] head_tag);
    logic [TAG_W-1:0] age_s;
    logic [TAG_W-1:0] ref_age_s;
    age_s     = tag - head_tag;
    ref_age_s = ref_tag - head_tag;
    return age_s > ref_age_s;
  endfunction

endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// Bus bundle between the functional units / ROB control and the CDB arbiter.
interface wb_cdb_arbiter_if;
  import wb_cdb_arbiter_pkg::*;

  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_ready;
  logic [N_SRC*PREG_W-1:0] src_prd;
  logic [N_SRC-1:0]        src_rd_used;
  logic [N_SRC*TAG_W-1:0]  src_rob_tag;
  logic [N_SRC*XLEN-1:0]   src_data;
  logic                    flush_i;
  logic                    recover_i;
  logic [TAG_W-1:0]        recover_tag_i;
  logic [TAG_W-1:0]        rob_head_tag;
  logic                    cdb_valid;
  logic [1:0]              cdb_src;
  logic [PREG_W-1:0]       cdb_prd;
  logic                    cdb_rd_used;
  logic [TAG_W-1:0]        cdb_rob_tag;
  logic [XLEN-1:0]         cdb_data;
  logic [15:0]             conflict_cnt;

  modport slave (
    input  src_valid, src_prd, src_rd_used, src_rob_tag, src_data,
    input  flush_i, recover_i, recover_tag_i, rob_head_tag,
    output src_ready, cdb_valid, cdb_src, cdb_prd, cdb_rd_used, cdb_rob_tag, cdb_data,
    output conflict_cnt
  );

  modport master (
    output src_valid, src_prd, src_rd_used, src_rob_tag, src_data,
    output flush_i, recover_i, recover_tag_i, rob_head_tag,
    input  src_ready, cdb_valid, cdb_src, cdb_prd, cdb_rd_used, cdb_rob_tag, cdb_data,
    input  conflict_cnt
  );
endinterface

// File: rtl/wb_cdb_arbiter_wb_queue.sv
// Per-source result FIFO; younger-than-branch entries are squashed and survivors compacted in order.
module wb_queue
  import wb_cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             recover,
  input  logic [TAG_W-1:0] recover_tag,
  input  logic [TAG_W-1:0] head_tag,
  input  logic             push_valid,
  input  cdb_pkt_t         push_pkt,
  input  logic             pop,
  output logic             push_ready,
  output cdb_pkt_t         head_pkt,
  output logic             occupied
);
  localparam int PTR_W = $clog2(DEPTH);

  cdb_pkt_t         mem_r [DEPTH];
  cdb_pkt_t         mem_n_s [DEPTH];
  cdb_pkt_t         ent_s [DEPTH];
  logic [PTR_W-1:0] slot_s [DEPTH];
  logic [PTR_W:0]   rd_ptr_r, wr_ptr_r, rd_n_s, wr_n_s, cnt_s, keep_cnt_s;
  logic [PTR_W-1:0] dst_s;
  logic [DEPTH-1:0] live_s;
  logic             pop_eff_s, push_keep_s;

  assign cnt_s = wr_ptr_r - rd_ptr_r;

  // live_s is in FIFO order (index 0 = head); reset and flush hide every entry at once.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign slot_s[i] = rd_ptr_r[PTR_W-1:0] + PTR_W'(i);
    assign ent_s[i]  = mem_r[slot_s[i]];
    assign live_s[i] = rst_n && !flush && ((PTR_W+1)'(i) < cnt_s) &&
                       !(recover && is_younger(ent_s[i].rob_tag, recover_tag, head_tag));
  end

  assign push_ready  = rst_n ? (cnt_s < (PTR_W+1)'(DEPTH)) : 1'b1;
  assign push_keep_s = rst_n && push_valid && push_ready && !flush &&
                       !(recover && is_younger(push_pkt.rob_tag, recover_tag, head_tag));
  assign pop_eff_s   = pop && live_s[0];
  assign occupied    = |live_s;

  // Head view presented to the arbiter; zero whenever the head is not live.
  always_comb begin
    head_pkt = '0;
    if (live_s[0]) begin
      head_pkt       = ent_s[0];
      head_pkt.valid = 1'b1;
    end else begin
      head_pkt = '0;
    end
  end

  // Rebuild the queue from the new read pointer: surviving entries in order, then the push.
  always_comb begin
    mem_n_s    = mem_r;
    keep_cnt_s = '0;
    dst_s      = '0;
    rd_n_s     = rd_ptr_r + {{PTR_W{1'b0}}, pop_eff_s};
    for (int i = 0; i < DEPTH; i++) begin
      if (live_s[i] && !(pop_eff_s && (i == 0))) begin
        dst_s          = rd_n_s[PTR_W-1:0] + keep_cnt_s[PTR_W-1:0];
        mem_n_s[dst_s] = ent_s[i];
        keep_cnt_s     = keep_cnt_s + (PTR_W+1)'(1);
      end else begin
        keep_cnt_s = keep_cnt_s;
      end
    end
    if (push_keep_s) begin
      dst_s          = rd_n_s[PTR_W-1:0] + keep_cnt_s[PTR_W-1:0];
      mem_n_s[dst_s] = push_pkt;
      keep_cnt_s     = keep_cnt_s + (PTR_W+1)'(1);
    end else begin
      keep_cnt_s = keep_cnt_s;
    end
    wr_n_s = rd_n_s + keep_cnt_s;
  end

  // Pointer and storage update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      rd_ptr_r <= rd_n_s;
      wr_ptr_r <= wr_n_s;
      mem_r    <= mem_n_s;
    end
  end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Round-robin arbitration of ALU/BRU/LSU writeback queues onto the single CDB.
module wb_cdb_arbiter
  import wb_cdb_arbiter_pkg::*;
#(
  parameter int Q_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_cdb_arbiter_if.slave bus
);
  localparam int OCC_W = $clog2(N_SRC + 1);

  cdb_pkt_t         push_pkt_s [N_SRC];
  cdb_pkt_t         head_pkt_s [N_SRC];
  cdb_pkt_t         sel_pkt_s;
  logic [N_SRC-1:0] head_vld_s, occ_s, ready_s, pop_s;
  logic [1:0]       rr_ptr_r, grant_idx_s;
  logic [2:0]       cand_s;
  logic             grant_any_s;
  logic [OCC_W-1:0] occ_cnt_s;
  logic [15:0]      conflict_cnt_r;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign push_pkt_s[g] = '{valid:   1'b1,
                             prd:     bus.src_prd[g*PREG_W +: PREG_W],
                             rd_used: bus.src_rd_used[g],
                             rob_tag: bus.src_rob_tag[g*TAG_W +: TAG_W],
                             data:    bus.src_data[g*XLEN +: XLEN]};
    assign head_vld_s[g] = head_pkt_s[g].valid;
    assign pop_s[g]      = grant_any_s && (grant_idx_s == 2'(g));

    wb_queue #(.DEPTH(Q_DEPTH)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (bus.flush_i),
      .recover     (bus.recover_i),
      .recover_tag (bus.recover_tag_i),
      .head_tag    (bus.rob_head_tag),
      .push_valid  (bus.src_valid[g]),
      .push_pkt    (push_pkt_s[g]),
      .pop         (pop_s[g]),
      .push_ready  (ready_s[g]),
      .head_pkt    (head_pkt_s[g]),
      .occupied    (occ_s[g])
    );
  end

  // Scan from the highest offset down so the nearest live head after rr_ptr wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = 2'd0;
    cand_s      = 3'd0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      cand_s = {1'b0, rr_ptr_r} + 3'(k);
      if (cand_s >= 3'(N_SRC)) begin
        cand_s = cand_s - 3'(N_SRC);
      end else begin
        cand_s = cand_s;
      end
      if (head_vld_s[cand_s[1:0]]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s[1:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // CDB mux; every field reads zero when nothing is granted.
  always_comb begin
    sel_pkt_s = '0;
    if (grant_any_s) begin
      sel_pkt_s = head_pkt_s[grant_idx_s];
    end else begin
      sel_pkt_s = '0;
    end
  end

  // Number of queues still holding live results this cycle.
  always_comb begin
    occ_cnt_s = '0;
    for (int k = 0; k < N_SRC; k++) begin
      occ_cnt_s = occ_cnt_s + OCC_W'(occ_s[k]);
    end
  end

  // Round-robin pointer follows the last grant and holds otherwise (including across flush).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= 2'd0;
    end else if (grant_any_s) begin
      rr_ptr_r <= (grant_idx_s == 2'(N_SRC - 1)) ? 2'd0 : grant_idx_s + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Saturating count of cycles with contention between queues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict_cnt_r <= 16'd0;
    end else if ((occ_cnt_s >= OCC_W'(2)) && (conflict_cnt_r != 16'hFFFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 16'd1;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign bus.src_ready    = ready_s;
  assign bus.cdb_valid    = grant_any_s;
  assign bus.cdb_src      = grant_any_s ? grant_idx_s : 2'd0;
  assign bus.cdb_prd      = sel_pkt_s.prd;
  assign bus.cdb_rd_used  = sel_pkt_s.rd_used;
  assign bus.cdb_rob_tag  = sel_pkt_s.rob_tag;
  assign bus.cdb_data     = sel_pkt_s.data;
  assign bus.conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Scoreboard bench: expected broadcasts are queued at issue time, a negedge monitor checks the CDB.
module tb_wb_cdb_arbiter;
  import wb_cdb_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]        src;
    logic [PREG_W-1:0] prd;
    logic              rd_used;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wb_cdb_arbiter_if bus();

  wb_cdb_arbiter #(.Q_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.src_valid = 3'b000;
    bus.flush_i   = 1'b0;
    bus.recover_i = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [PREG_W-1:0] prd, input logic ru,
                         input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
    bus.src_valid[s]                   = 1'b1;
    bus.src_prd[s*PREG_W +: PREG_W]    = prd;
    bus.src_rd_used[s]                 = ru;
    bus.src_rob_tag[s*TAG_W +: TAG_W]  = tag;
    bus.src_data[s*XLEN +: XLEN]       = data;
  endtask

  task automatic expect_cdb(input int s, input logic [PREG_W-1:0] prd, input logic ru,
                            input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] data);
    exp_q.push_back('{src: 2'(s), prd: prd, rd_used: ru, tag: tag, data: data});
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: every broadcast must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cdb_unexpected: got src=%0d tag=%0d data=%0h, required no broadcast",
                 bus.cdb_src, bus.cdb_rob_tag, bus.cdb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cdb_pkt", {bus.cdb_src, bus.cdb_prd, bus.cdb_rd_used, bus.cdb_rob_tag, bus.cdb_data}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.src_valid     = 3'b000;
    bus.src_prd       = '0;
    bus.src_rd_used   = '0;
    bus.src_rob_tag   = '0;
    bus.src_data      = '0;
    bus.flush_i       = 1'b0;
    bus.recover_i     = 1'b0;
    bus.recover_tag_i = 4'd0;
    bus.rob_head_tag  = 4'd0;
    rst_n             = 1'b0;
    tick();
    tick();
    #3;
    check("reset_ready", 64'(bus.src_ready), 64'h7);
    check("reset_cdb_valid", 64'(bus.cdb_valid), 64'h0);
    check("reset_conflict", 64'(bus.conflict_cnt), 64'h0);
    tick();
    rst_n = 1'b1;

    // Test 1: single ALU result, visible only in the following cycle.
    set_src(0, 7'd33, 1'b1, 4'd2, 32'h1234);
    expect_cdb(0, 7'd33, 1'b1, 4'd2, 32'h1234);
    #3;
    check("t1_no_bypass", 64'(bus.cdb_valid), 64'h0);
    tick();
    clear_in();
    tick();
    tick();

    // Test 2: all sources push for 6 cycles.
    do_reset();
    expect_cdb(0, 7'd0,  1'b1, 4'd0, 32'h000);
    expect_cdb(1, 7'd16, 1'b1, 4'd0, 32'h100);
    expect_cdb(2, 7'd32, 1'b1, 4'd0, 32'h200);
    expect_cdb(0, 7'd1,  1'b1, 4'd1, 32'h001);
    expect_cdb(1, 7'd17, 1'b1, 4'd1, 32'h101);
    expect_cdb(2, 7'd33, 1'b1, 4'd1, 32'h201);
    expect_cdb(0, 7'd2,  1'b1, 4'd2, 32'h002);
    expect_cdb(1, 7'd19, 1'b1, 4'd3, 32'h103);
    expect_cdb(2, 7'd36, 1'b1, 4'd4, 32'h204);
    expect_cdb(0, 7'd5,  1'b1, 4'd5, 32'h005);
    begin
      logic [2:0] ready_tbl [6];
      ready_tbl = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001};
      for (int c = 0; c < 6; c++) begin
        for (int s = 0; s < 3; s++) begin
          set_src(s, 7'(s * 16 + c), 1'b1, 4'(c), 32'(s * 256 + c));
        end
        #3;
        check($sformatf("t2_ready_c%0d", c), 64'(bus.src_ready), 64'(ready_tbl[c]));
        tick();
      end
    end
    clear_in();
    for (int c = 0; c < 5; c++) begin
      tick();
    end
    #3;
    check("t2_conflict_cnt", 64'(bus.conflict_cnt), 64'd9);
    tick();

    // Test 3: recovery squashes younger queued heads.
    do_reset();
    bus.rob_head_tag = 4'd0;
    set_src(0, 7'd3, 1'b1, 4'd3, 32'h33);
    set_src(1, 7'd5, 1'b1, 4'd5, 32'h55);
    expect_cdb(0, 7'd3, 1'b1, 4'd3, 32'h33);
    tick();
    clear_in();
    set_src(0, 7'd7, 1'b1, 4'd7, 32'h77);
    tick();
    clear_in();
    bus.recover_i     = 1'b1;
    bus.recover_tag_i = 4'd4;
    #3;
    check("t3_recover_mask", 64'(bus.cdb_valid), 64'h0);
    tick();
    clear_in();
    #3;
    check("t3_ready", 64'(bus.src_ready), 64'h7);
    tick();
    tick();

    // Test 4: tag wrap around the ROB head, with compaction behind a squashed head.
    do_reset();
    bus.rob_head_tag = 4'd14;
    set_src(0, 7'd1, 1'b0, 4'd13, 32'hD0);
    expect_cdb(0, 7'd1, 1'b0, 4'd13, 32'hD0);
    tick();
    clear_in();
    set_src(0, 7'd10, 1'b1, 4'd0, 32'hA0);
    set_src(1, 7'd14, 1'b1, 4'd14, 32'hE14);
    expect_cdb(1, 7'd14, 1'b1, 4'd14, 32'hE14);
    tick();
    clear_in();
    set_src(0, 7'd15, 1'b1, 4'd15, 32'hF15);
    expect_cdb(0, 7'd15, 1'b1, 4'd15, 32'hF15);
    tick();
    clear_in();
    bus.recover_i     = 1'b1;
    bus.recover_tag_i = 4'd15;
    set_src(2, 7'd20, 1'b1, 4'd1, 32'hBAD);
    #3;
    check("t4_recover_mask", 64'(bus.cdb_valid), 64'h0);
    tick();
    clear_in();
    #3;
    check("t4_ready", 64'(bus.src_ready), 64'h7);
    tick();
    tick();

    // Test 5: flush with four queued entries and a simultaneous LSU push.
    do_reset();
    bus.rob_head_tag = 4'd0;
    set_src(0, 7'd1, 1'b1, 4'd1, 32'h501);
    set_src(1, 7'd2, 1'b1, 4'd2, 32'h502);
    set_src(2, 7'd3, 1'b1, 4'd3, 32'h503);
    expect_cdb(0, 7'd1, 1'b1, 4'd1, 32'h501);
    tick();
    clear_in();
    set_src(0, 7'd4, 1'b1, 4'd4, 32'h504);
    set_src(1, 7'd5, 1'b1, 4'd5, 32'h505);
    tick();
    clear_in();
    bus.flush_i = 1'b1;
    set_src(2, 7'd6, 1'b1, 4'd6, 32'h506);
    #3;
    check("t5_flush_valid", 64'(bus.cdb_valid), 64'h0);
    tick();
    clear_in();
    #3;
    check("t5_ready_after", 64'(bus.src_ready), 64'h7);
    check("t5_valid_after", 64'(bus.cdb_valid), 64'h0);
    set_src(0, 7'd7, 1'b1, 4'd7, 32'h507);
    set_src(1, 7'd8, 1'b1, 4'd8, 32'h508);
    expect_cdb(1, 7'd8, 1'b1, 4'd8, 32'h508);
    expect_cdb(0, 7'd7, 1'b1, 4'd7, 32'h507);
    tick();
    clear_in();
    tick();
    tick();

    // Test 6: reset while results are pending.
    do_reset();
    set_src(0, 7'd1, 1'b1, 4'd1, 32'h601);
    set_src(1, 7'd2, 1'b1, 4'd2, 32'h602);
    set_src(2, 7'd3, 1'b1, 4'd3, 32'h603);
    expect_cdb(0, 7'd1, 1'b1, 4'd1, 32'h601);
    tick();
    clear_in();
    tick();
    rst_n = 1'b0;
    #3;
    check("t6_conflict_before", 64'(bus.conflict_cnt), 64'd1);
    check("t6_valid_in_reset", 64'(bus.cdb_valid), 64'h0);
    check("t6_ready_in_reset", 64'(bus.src_ready), 64'h7);
    tick();
    rst_n = 1'b1;
    #3;
    check("t6_conflict_after", 64'(bus.conflict_cnt), 64'd0);
    check("t6_ready_after", 64'(bus.src_ready), 64'h7);
    check("t6_valid_after", 64'(bus.cdb_valid), 64'h0);
    tick();
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
